mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 20 ++
 rtl/mem_responder.sv | 110 +++++++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Processor-to-memory request/response bundle for mem_responder.
// The master drives the request side; the memory responder is the slave.
interface mem_responder_if;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency tagged memory model: grants the lowest free tag per request,
// and returns load data MEM_LATENCY cycles after acceptance.
module mem_responder #(
  parameter int MEM_LATENCY = 4,
  parameter int NUM_TAGS    = 15,
  parameter int MEM_WORDS   = 1024
) (
  input logic            clock,
  input logic            reset,
  mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic [63:0]         mem_q [MEM_WORDS];
  logic [IDX_W-1:0]    idx;
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [3:0]          grant_tag;
  logic                grant_found;
  logic                is_load, is_store, accept;
  logic                unused_addr_bits;

  logic                pipe_valid_q [MEM_LATENCY];
  logic                pipe_valid_d [MEM_LATENCY];
  logic                pipe_load_q  [MEM_LATENCY];
  logic                pipe_load_d  [MEM_LATENCY];
  logic [3:0]          pipe_tag_q   [MEM_LATENCY];
  logic [3:0]          pipe_tag_d   [MEM_LATENCY];
  logic [63:0]         pipe_data_q  [MEM_LATENCY];

  logic                fin_valid, fin_load;
  logic [3:0]          fin_tag;

  assign idx              = bus.proc2mem_addr[3 +: IDX_W];
  assign unused_addr_bits = ^bus.proc2mem_addr;
  assign is_load          = (bus.proc2mem_command == BUS_LOAD);
  assign is_store         = (bus.proc2mem_command == BUS_STORE);

  // Scan downward so the last hit is the lowest-numbered free tag.
  always_comb begin
    grant_found = 1'b0;
    grant_tag   = 4'd0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        grant_found = 1'b1;
        grant_tag   = 4'(i + 1);
      end
    end
  end

  assign accept                = !reset && (is_load || is_store) && grant_found;
  assign bus.mem2proc_response = accept ? grant_tag : 4'd0;

  assign fin_valid = pipe_valid_q[MEM_LATENCY-1];
  assign fin_load  = pipe_load_q[MEM_LATENCY-1];
  assign fin_tag   = pipe_tag_q[MEM_LATENCY-1];

  // Release and grant never hit the same tag: a granted tag was free.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (fin_valid && fin_tag == 4'(i + 1)) busy_d[i] = 1'b0;
      if (accept && grant_tag == 4'(i + 1))  busy_d[i] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MEM_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign pipe_valid_d[gi] = accept;
        assign pipe_load_d[gi]  = is_load;
        assign pipe_tag_d[gi]   = grant_tag;
      end else begin : g_shift
        assign pipe_valid_d[gi] = pipe_valid_q[gi-1];
        assign pipe_load_d[gi]  = pipe_load_q[gi-1];
        assign pipe_tag_d[gi]   = pipe_tag_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
      for (int s = 0; s < MEM_LATENCY; s++) begin
        pipe_valid_q[s] <= 1'b0;
        pipe_load_q[s]  <= 1'b0;
        pipe_tag_q[s]   <= 4'd0;
      end
    end else begin
      busy_q <= busy_d;
      for (int s = 0; s < MEM_LATENCY; s++) begin
        pipe_valid_q[s] <= pipe_valid_d[s];
        pipe_load_q[s]  <= pipe_load_d[s];
        pipe_tag_q[s]   <= pipe_tag_d[s];
      end
    end
  end

  // Storage survives reset; the registered read feeds the head data stage.
  always_ff @(posedge clock) begin
    if (accept && is_store) mem_q[idx] <= bus.proc2mem_data;
    pipe_data_q[0] <= mem_q[idx];
    for (int s = 1; s < MEM_LATENCY; s++) pipe_data_q[s] <= pipe_data_q[s-1];
  end

  assign bus.mem2proc_tag  = (fin_valid && fin_load) ? fin_tag : 4'd0;
  assign bus.mem2proc_data = (fin_valid && fin_load) ? pipe_data_q[MEM_LATENCY-1] : 64'd0;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder with a small tag pool so that
// tag exhaustion, release timing, reset drops and aliasing all get exercised.
module tb_mem_responder;
  localparam int LAT   = 4;
  localparam int NT    = 3;
  localparam int WORDS = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_responder_if bus();

  mem_responder #(.MEM_LATENCY(LAT), .NUM_TAGS(NT), .MEM_WORDS(WORDS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } comp_t;

  comp_t       comp_q [$];
  logic [3:0]  resp_q [$];
  logic [63:0] mem_m  [int];
  int          free_at [1:NT];
  int          idx_set [8];
  int          cyc = -1;
  int          checks = 0;
  int          failures = 0;

  // Reference: a tag is grantable once the current cycle reaches free_at.
  task automatic drive(input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [63:0] wd, input logic rst,
                       output int got);
    int g;
    int idx;
    @(posedge clock);
    #1;
    cyc++;
    reset                = rst;
    bus.proc2mem_command = cmd;
    bus.proc2mem_addr    = addr;
    bus.proc2mem_data    = wd;
    g = 0;
    if (!rst && (cmd == 2'd1 || cmd == 2'd2))
      for (int t = NT; t >= 1; t--) if (free_at[t] <= cyc) g = t;
    resp_q.push_back(4'(g));
    idx = int'((addr >> 3) % WORDS);
    if (g != 0) begin
      free_at[g] = cyc + LAT + 1;
      if (cmd == 2'd2) mem_m[idx] = wd;
      else comp_q.push_back('{cyc + LAT, 4'(g), mem_m[idx]});
    end
    if (rst) begin
      for (int t = 1; t <= NT; t++) free_at[t] = cyc + 1;
      while (comp_q.size() > 0 && comp_q[$].due > cyc) void'(comp_q.pop_back());
    end
    got = g;
  endtask

  task automatic issue_until(input logic [1:0] cmd, input logic [31:0] addr,
                             input logic [63:0] wd);
    int got;
    int tries;
    tries = 0;
    got   = 0;
    while (got == 0 && tries < 64) begin
      drive(cmd, addr, wd, 1'b0, got);
      tries++;
    end
    if (got == 0) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout cyc=%0d cmd=%0d got_grant=none required=grant", cyc, cmd);
    end
  endtask

  task automatic idle(input int n);
    int got;
    for (int i = 0; i < n; i++) drive(2'd0, 32'h0, 64'h0, 1'b0, got);
  endtask

  always @(negedge clock) begin
    if (cyc >= 0) begin
      logic [3:0] exp_r;
      comp_t c;
      exp_r = (resp_q.size() > 0) ? resp_q.pop_front() : 4'd0;
      checks++;
      if (bus.mem2proc_response !== exp_r) begin
        failures++;
        $display("FAIL response cyc=%0d got=%0d exp=%0d", cyc, bus.mem2proc_response, exp_r);
      end
      if (cyc >= 1) begin
        checks++;
        if (comp_q.size() > 0 && comp_q[0].due == cyc) begin
          c = comp_q.pop_front();
          if (bus.mem2proc_tag !== c.tag || bus.mem2proc_data !== c.data) begin
            failures++;
            $display("FAIL completion cyc=%0d got_tag=%0d got_data=%h exp_tag=%0d exp_data=%h",
                     cyc, bus.mem2proc_tag, bus.mem2proc_data, c.tag, c.data);
          end
        end else if (bus.mem2proc_tag !== 4'd0 || bus.mem2proc_data !== 64'd0) begin
          failures++;
          $display("FAIL idle_output cyc=%0d got_tag=%0d got_data=%h exp_tag=0 exp_data=0",
                   cyc, bus.mem2proc_tag, bus.mem2proc_data);
        end
      end
    end
  end

  initial begin
    int got;
    int k;
    int r;
    logic [1:0] cmd;
    logic [31:0] addr;
    bus.proc2mem_command = 2'd0;
    bus.proc2mem_addr    = 32'h0;
    bus.proc2mem_data    = 64'h0;
    for (int t = 1; t <= NT; t++) free_at[t] = 0;
    for (int i = 0; i < 8; i++) idx_set[i] = (i * 131) % WORDS;

    // Reset with a LOAD presented: response must stay 0.
    for (int i = 0; i < 3; i++) drive(2'd1, 32'h100, 64'h0, 1'b1, got);
    $display("reset phase done cyc=%0d", cyc);

    // Store then load at 0x100, back to back.
    drive(2'd2, 32'h100, 64'hDEADBEEF_CAFEF00D, 1'b0, got);
    $display("store 0x100 grant=%0d", got);
    drive(2'd1, 32'h100, 64'h0, 1'b0, got);
    $display("load 0x100 grant=%0d", got);
    // Aliasing: 0x2008 and 0x000C share word index 1.
    issue_until(2'd2, 32'h2008, 64'h0123_4567_89AB_CDEF);
    issue_until(2'd1, 32'h000C, 64'h0);
    $display("alias store/load issued cyc=%0d", cyc);
    // Reserved command must not write.
    drive(2'd3, 32'h000C, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, got);
    issue_until(2'd1, 32'h000C, 64'h0);
    $display("reserved command probe cyc=%0d", cyc);

    for (int i = 0; i < 8; i++)
      issue_until(2'd2, 32'(idx_set[i]) << 3, {$urandom(), $urandom()});
    $display("prefill done cyc=%0d", cyc);

    // Exhaustion: continuous loads against a small tag pool.
    idle(LAT + 2);
    for (int i = 0; i < 10; i++) begin
      drive(2'd1, 32'(idx_set[i % 8]) << 3, 64'h0, 1'b0, got);
      $display("exhaust load %0d cyc=%0d grant=%0d", i, cyc, got);
    end

    // Reset mid-flight drops in-flight loads; next load gets tag 1.
    idle(LAT + 2);
    for (int i = 0; i < 3; i++) drive(2'd1, 32'(idx_set[i]) << 3, 64'h0, 1'b0, got);
    drive(2'd0, 32'h0, 64'h0, 1'b1, got);
    idle(1);
    drive(2'd1, 32'(idx_set[5]) << 3, 64'h0, 1'b0, got);
    $display("post-reset load cyc=%0d grant=%0d", cyc, got);
    idle(LAT + 2);

    // Mixed alternating stream.
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 2'd1 : 2'd2, 32'(idx_set[i % 8]) << 3,
            {$urandom(), $urandom()}, 1'b0, got);
      $display("mixed %0d cyc=%0d grant=%0d", i, cyc, got);
    end

    // Random traffic with aliased upper bits and random byte offsets.
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      k = int'($urandom_range(0, 7));
      addr = ($urandom() & ~32'h0000_1FF8) | (32'(idx_set[k]) << 3);
      if (r < 40)      cmd = 2'd1;
      else if (r < 70) cmd = 2'd2;
      else if (r < 85) cmd = 2'd0;
      else             cmd = 2'd3;
      drive(cmd, addr, {$urandom(), $urandom()}, (r == 99), got);
      $display("rand %0d cyc=%0d cmd=%0d idx=%0d rst=%0d grant=%0d",
               i, cyc, cmd, idx_set[k], (r == 99), got);
    end

    idle(LAT + 3);
    @(posedge clock);
    #2;
    checks++;
    if (comp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", comp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
